// File: rtl/rr_arbiter_param.sv
// -----------------------------------------------------------------------------
// rr_arbiter_param
//
// Round-robin arbiter for the NOC router. It grants one of NUM_REQ requesters
// at a time and holds the grant until the packet completes. A registered
// one-hot priority pointer moves past the last winner when a grant is
// released, so the requester that just finished has the lowest priority in the
// next arbitration.
//
// Parameters
//   NUM_REQ   number of requesters (1..32)
//   MAX_HOLD  maximum grant hold in cycles (>= 2); used only when the
//             RR_HOLD_TIMEOUT_EN macro is defined
//   IDX_W     derived index width, max(1, $clog2(NUM_REQ)); not overridable
//
// Compile-time option
//   RR_HOLD_TIMEOUT_EN  when defined, a grant held for MAX_HOLD cycles without
//                       done_i is released by force and timeout_o pulses.
//                       When undefined, timeout_o is always 0 and a grant is
//                       held until done_i.
//
// Ports
//   clk               single clock, rising-edge
//   reset_n           asynchronous active-low reset
//   req_i             per-requester request levels
//   done_i            last transfer of the current grant (ignored without a grant)
//   grant_o           registered one-hot grant
//   grant_valid_o     high while grant_o is non-zero
//   grant_idx_o       binary index of the granted requester, 0 with no grant
//   priority_order_o  one-hot pointer to the highest-priority requester
//   timeout_o         one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module rr_arbiter_param #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               done_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_valid_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic [NUM_REQ-1:0] priority_order_o,
    output logic               timeout_o
);

    localparam logic [NUM_REQ-1:0] LSB_ONE = NUM_REQ'(1'b1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // First set request searching circularly upward from the pointer bit,
    // inclusive. Bits at or above the pointer are tried first; if none of
    // those request, the search wraps to the lowest set request bit.
    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [NUM_REQ-1:0] ptr
    );
        logic [NUM_REQ-1:0] upper;
        logic [NUM_REQ-1:0] masked;
        logic [NUM_REQ-1:0] pick;
        upper  = ~(ptr - LSB_ONE);
        masked = req & upper;
        if (|masked) begin
            pick = masked & (~masked + LSB_ONE);
        end else begin
            pick = req & (~req + LSB_ONE);
        end
        return pick;
    endfunction

    // Rotate left by one, bit NUM_REQ-1 wrapping to bit 0 (identity for 1 bit).
    function automatic logic [NUM_REQ-1:0] rotl1(input logic [NUM_REQ-1:0] v);
        logic [NUM_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            r[(i + 1) % NUM_REQ] = v[i];
        end
        return r;
    endfunction

    // Binary encode of a one-hot (or zero) vector; zero encodes to 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_r;
    state_t             state_s;
    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] grant_s;
    logic               valid_r;
    logic [IDX_W-1:0]   idx_r;
    logic [NUM_REQ-1:0] ptr_r;
    logic [NUM_REQ-1:0] ptr_s;
    logic               timeout_r;
    logic               timeout_s;
    logic               release_s;
    logic               forced_s;
    // Arbitration is held off for the first edge after reset release, so the
    // earliest grant is loaded on the second rising edge after deassertion.
    logic               arm_r;

`ifdef RR_HOLD_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_s;
`endif

    // Next-state, next-grant and pointer update logic.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        ptr_s     = ptr_r;
        release_s = 1'b0;
        forced_s  = 1'b0;
`ifdef RR_HOLD_TIMEOUT_EN
        hold_s    = hold_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // done_i is meaningless without a grant and is not looked at.
                if (arm_r && (|req_i)) begin
                    grant_s = rr_pick(req_i, ptr_r);
                    state_s = ST_GRANT;
`ifdef RR_HOLD_TIMEOUT_EN
                    hold_s  = HOLD_W'(1);
`endif
                end else begin
                    grant_s = '0;
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // The grant is locked here: req_i only matters on release.
                if (done_i) begin
                    release_s = 1'b1;
`ifdef RR_HOLD_TIMEOUT_EN
                end else if (hold_r >= HOLD_W'(MAX_HOLD)) begin
                    release_s = 1'b1;
                    forced_s  = 1'b1;
                end else begin
                    hold_s    = hold_r + HOLD_W'(1);
                end
`else
                end else begin
                    release_s = 1'b0;
                end
`endif
                if (release_s) begin
                    // Releasing requester becomes lowest priority, then the
                    // new pointer is used for back-to-back re-arbitration.
                    ptr_s = rotl1(grant_r);
                    if (|req_i) begin
                        grant_s = rr_pick(req_i, ptr_s);
                        state_s = ST_GRANT;
`ifdef RR_HOLD_TIMEOUT_EN
                        hold_s  = HOLD_W'(1);
`endif
                    end else begin
                        grant_s = '0;
                        state_s = ST_IDLE;
                    end
                end else begin
                    grant_s = grant_r;
                    state_s = ST_GRANT;
                end
            end
            default: begin
                grant_s = '0;
                state_s = ST_IDLE;
            end
        endcase
        timeout_s = forced_s;
    end

    // State, grant, pointer and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            valid_r   <= 1'b0;
            idx_r     <= '0;
            ptr_r     <= LSB_ONE;
            timeout_r <= 1'b0;
            arm_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            valid_r   <= |grant_s;
            idx_r     <= onehot_to_idx(grant_s);
            ptr_r     <= ptr_s;
            timeout_r <= timeout_s;
            arm_r     <= 1'b1;
        end
    end

`ifdef RR_HOLD_TIMEOUT_EN
    // Hold counter: cycles the current grant has been visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_r <= '0;
        end else begin
            hold_r <= hold_s;
        end
    end
`endif

    assign grant_o          = grant_r;
    assign grant_valid_o    = valid_r;
    assign grant_idx_o      = idx_r;
    assign priority_order_o = ptr_r;
    assign timeout_o        = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_param
//
// Directed bench for rr_arbiter_param with NUM_REQ=4, MAX_HOLD=8. A table of
// {req, done, expected grant/index/pointer/timeout} records drives the
// steady-state arbitration; hand-written sequences cover reset release, long
// holds (forced release when RR_HOLD_TIMEOUT_EN is defined) and reset in the
// middle of a grant.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_param;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] priority_order;
    logic       timeout;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] idx;
        logic [3:0] ptr;
        logic       to;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    rr_arbiter_param #(
        .NUM_REQ  (4),
        .MAX_HOLD (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_i            (req),
        .done_i           (done),
        .grant_o          (grant),
        .grant_valid_o    (grant_valid),
        .grant_idx_o      (grant_idx),
        .priority_order_o (priority_order),
        .timeout_o        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] idx,
                             input logic [3:0] ptr, input logic to);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".valid"}, 32'(grant_valid), 32'(|g));
        check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
        check({tag, ".ptr"}, 32'(priority_order), 32'(ptr));
        check({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    // One clock edge, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //          req      done  grant    idx   ptr      to
        vecs[0]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b0}; // full load
        vecs[1]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 4'b1000, 1'b0};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b0}; // wrap, no bubble
        vecs[4]  = '{4'b1001, 1'b1, 4'b1000, 2'd3, 4'b0010, 1'b0}; // fairness skip
        vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0001, 1'b0}; // release to idle
        vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0001, 1'b0}; // done ignored idle
        vecs[7]  = '{4'b0011, 1'b0, 4'b0001, 2'd0, 4'b0001, 1'b0}; // lock cycle 1
        vecs[8]  = '{4'b0011, 1'b0, 4'b0001, 2'd0, 4'b0001, 1'b0};
        vecs[9]  = '{4'b0010, 1'b0, 4'b0001, 2'd0, 4'b0001, 1'b0}; // granted bit drops
        vecs[10] = '{4'b0011, 1'b0, 4'b0001, 2'd0, 4'b0001, 1'b0};
        vecs[11] = '{4'b0011, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b0}; // done in cycle 5
        vecs[12] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0100, 1'b0};
        vecs[13] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 4'b0100, 1'b0}; // circular wrap
        vecs[14] = '{4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0010, 1'b0}; // 1-cycle grant, re-grant
        vecs[15] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0010, 1'b0};

        // ---- Reset with all requests high ----
        reset_n = 1'b0;
        req     = 4'b1111;
        done    = 1'b0;
        step();
        check_all("reset0", 4'b0000, 2'd0, 4'b0001, 1'b0);
        step();
        check_all("reset1", 4'b0000, 2'd0, 4'b0001, 1'b0);

        // ---- Release reset: grant on second rising edge ----
        reset_n = 1'b1;
        step();
        check_all("post_rst_edge1", 4'b0000, 2'd0, 4'b0001, 1'b0);
        step();
        check_all("post_rst_edge2", 4'b0001, 2'd0, 4'b0001, 1'b0);

        // ---- Table-driven steady-state vectors ----
        for (int i = 0; i < NVEC; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].ptr, vecs[i].to);
        end

        // ---- Long hold on bit 2 (pointer 0010, idle) ----
        req  = 4'b0100;
        done = 1'b0;
        step();
        check_all("hold_c1", 4'b0100, 2'd2, 4'b0010, 1'b0);
`ifdef RR_HOLD_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            step();
            check_all($sformatf("hold_c%0d", c), 4'b0100, 2'd2, 4'b0010, 1'b0);
        end
        step();
        check_all("hold_forced", 4'b0100, 2'd2, 4'b1000, 1'b1);
        req  = 4'b0000;
        done = 1'b1;
        step();
        check_all("hold_end", 4'b0000, 2'd0, 4'b1000, 1'b0);
`else
        for (int c = 2; c <= 20; c++) begin
            step();
            check_all($sformatf("hold_c%0d", c), 4'b0100, 2'd2, 4'b0010, 1'b0);
        end
        req  = 4'b0000;
        done = 1'b1;
        step();
        check_all("hold_end", 4'b0000, 2'd0, 4'b1000, 1'b0);
`endif

        // ---- Reset in the 3rd cycle of a 0100 grant (pointer 1000) ----
        req  = 4'b0100;
        done = 1'b0;
        step();
        check_all("mid_c1", 4'b0100, 2'd2, 4'b1000, 1'b0);
        step();
        step();
        check_all("mid_c3", 4'b0100, 2'd2, 4'b1000, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("mid_async", 4'b0000, 2'd0, 4'b0001, 1'b0);
        step();
        check_all("mid_held", 4'b0000, 2'd0, 4'b0001, 1'b0);
        reset_n = 1'b1;
        step();
        check_all("mid_rel1", 4'b0000, 2'd0, 4'b0001, 1'b0);
        step();
        check_all("mid_rel2", 4'b0100, 2'd2, 4'b0001, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_param.md
# rr_arbiter_param

Parametrised round-robin arbiter for the NOC router: grants one of `NUM_REQ` requesters at a time and holds the grant until the packet completes. It keeps a registered one-hot priority pointer that advances past the last winner, giving true round-robin fairness rather than a blind rotation. It sits between input-port request logic and the crossbar select, and supersedes the fixed 4-entry rotating priority register.

## Interface
- `NUM_REQ`, 4, number of requesters, legal range 1..32
- `MAX_HOLD`, 16, maximum grant hold in cycles; used only with `RR_HOLD_TIMEOUT_EN`; legal range >= 2
- `IDX_W`, derived as max(1, $clog2(NUM_REQ)); not overridable
- `clk` in 1: single clock; all state updates on its rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `req_i` in NUM_REQ: per-requester request level
- `done_i` in 1: last transfer of the current grant; sampled only while `grant_valid_o`=1
- `grant_o` out NUM_REQ: registered one-hot grant
- `grant_valid_o` out 1: high when `grant_o` is non-zero
- `grant_idx_o` out IDX_W: binary index of the granted requester; 0 when no grant
- `priority_order_o` out NUM_REQ: one-hot pointer to the highest-priority requester
- `timeout_o` out 1: one-cycle pulse on forced release

## Operation
- Reset values: `grant_o`=0, `grant_valid_o`=0, `grant_idx_o`=0, `timeout_o`=0, `priority_order_o`=1 (bit 0), state IDLE.
- State IDLE
  - If `req_i` is non-zero, select the first set bit searching circularly upward from the pointer bit, inclusive.
  - Register that bit as `grant_o`, then go to GRANT.
  - If `req_i` is zero, stay in IDLE with all outputs zero.
- State GRANT
  - `grant_o` is locked; changes on `req_i`, including the granted bit dropping, are ignored.
  - Release happens only on `done_i`=1, or on timeout when the feature is compiled in.
- On release
  - Pointer <= `grant_o` rotated left by 1, wrapping bit NUM_REQ-1 to bit 0.
  - In the same edge, re-arbitrate with the new pointer. The releasing requester is therefore lowest priority.
  - If any request is present, load the new grant and stay in GRANT (back-to-back, no bubble). Otherwise go to IDLE.
- The pointer changes only on release, never in IDLE.
- `NUM_REQ`=1: the pointer is constantly 1 and requester 0 always wins on request.
- `grant_idx_o` is the binary encode of `grant_o`, registered alongside it.

## Timing
- Arbitration latency: `req_i` sampled at edge t in IDLE gives `grant_o` valid from t+1.
- Release: `done_i`=1 at edge t ends the grant at t. Either the next grant or zero is visible from t+1.
- Minimum grant length is 1 cycle. `done_i` in the first grant cycle is legal.
- Asynchronous `reset_n` assertion mid-grant clears the grant, pointer and state immediately. No pointer advance is recorded for the aborted grant.
- Reset deassertion is followed by the first possible grant on the second rising edge after deassertion.
- `done_i` while `grant_valid_o`=0 is ignored.

## Configuration
- `RR_HOLD_TIMEOUT_EN` defined
  - A hold counter clears on every new grant and increments each GRANT cycle.
  - When the grant has been valid for `MAX_HOLD` cycles with `done_i`=0, the release is forced exactly as for `done_i`: pointer advances, re-arbitration runs.
  - `timeout_o` is high for the single cycle after the forced-release edge.
  - A `done_i` arriving at the same edge as the timeout counts as a normal release; `timeout_o` stays 0.
- `RR_HOLD_TIMEOUT_EN` not defined: no counter; `timeout_o` is tied 0; `MAX_HOLD` is ignored; grants are held indefinitely until `done_i`.

## Test plan
(all with NUM_REQ=4)
- Reset: apply `reset_n`=0 with `req_i`=4'b1111 -> all outputs 0 and `priority_order_o`=4'b0001 throughout reset.
- Full load: `req_i`=4'b1111 and `done_i`=1 every cycle -> `grant_o` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no bubble.
- Fairness skip: after granting 0001 (pointer now 0010), drive `req_i`=4'b1001 -> `grant_o`=1000, `grant_idx_o`=3, then pointer=0001.
- Lock: `req_i`=4'b0011 with `done_i` held 0 for 5 cycles -> `grant_o` stays 0001 for 5 cycles; `done_i`=1 on cycle 5 -> `grant_o`=0010 the next cycle.
- Timeout (macro on, MAX_HOLD=8): single request on bit 2 with `done_i`=0 -> grant held exactly 8 cycles, `timeout_o` pulses once, pointer=1000.
- Reset mid-grant: assert `reset_n`=0 on the 3rd cycle of a 0100 grant -> `grant_o`=0 immediately and pointer=0001.
